// File: rtl/min_sad_tracker.sv
// Running-minimum tracker over NUM_COLS compare-tree column results.
// Emits the block-minimum SAD and its (x, y) motion vector through a valid/ready output register.
module min_sad_tracker #(
  parameter int SAD_W    = 14,
  parameter int MVY_W    = 4,
  parameter int MVX_W    = 4,
  parameter int NUM_COLS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SAD_W-1:0] in_sad,
  input  logic [MVY_W-1:0] in_mvy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SAD_W-1:0] out_sad,
  output logic [MVX_W-1:0] out_mvx,
  output logic [MVY_W-1:0] out_mvy
);

  localparam logic [MVX_W-1:0] LAST_COL = MVX_W'(NUM_COLS - 1);
  localparam logic [MVX_W-1:0] COL_ONE  = MVX_W'(1);

  logic [MVX_W-1:0] col;
  logic [SAD_W-1:0] best_sad;
  logic [MVX_W-1:0] best_mvx;
  logic [MVY_W-1:0] best_mvy;

  logic last_col;
  logic in_xfer;
  logic out_xfer;
  logic take;

  // Strict unsigned less-than: ties keep the earlier (lower x) column.
  function automatic logic beats(input logic [SAD_W-1:0] cand, input logic [SAD_W-1:0] best);
    return cand < best;
  endfunction

  assign last_col = (col == LAST_COL);
  assign in_ready = !(last_col && out_valid && !out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign take     = (col == '0) || beats(in_sad, best_sad);

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      best_sad  <= '1;
      best_mvx  <= '0;
      best_mvy  <= '0;
      out_valid <= 1'b0;
      out_sad   <= '0;
      out_mvx   <= '0;
      out_mvy   <= '0;
    end else begin
      if (out_xfer)
        out_valid <= 1'b0;
      if (in_xfer) begin
        if (last_col) begin
          // Final column resolves straight into the output register; overrides any drain.
          col       <= '0;
          out_valid <= 1'b1;
          out_sad   <= take ? in_sad : best_sad;
          out_mvx   <= take ? col    : best_mvx;
          out_mvy   <= take ? in_mvy : best_mvy;
        end else begin
          col <= col + COL_ONE;
          if (take) begin
            best_sad <= in_sad;
            best_mvx <= col;
            best_mvy <= in_mvy;
          end
        end
      end
    end
  end

endmodule
